// File: rtl/vlc_input_conditioner.sv
// vlc_input_conditioner
// Synchronises, debounces and arbitrates the raw driver controls (left stalk,
// right stalk, hazard button) into clean levels for the lighting controller.
//
// Turn FSM states:
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | no turn request, or both stalks conflicting
//   ST_LEFT  | left request owns the indicator
//   ST_RIGHT | right request owns the indicator
//
// The hazard latch masks both turn outputs while set; the FSM keeps tracking
// the stalks underneath so the correct turn reappears when hazard clears.
module vlc_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_left,
  input  logic sw_right,
  input  logic sw_hazard,
  output logic Turn_Left,
  output logic Turn_Right,
  output logic Emergency
);

  localparam int unsigned CH_L = 0;
  localparam int unsigned CH_R = 1;
  localparam int unsigned CH_H = 2;

  // Terminal count of the per-channel run counter.
  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } turn_state_e;

  logic [2:0]      raw;
  logic [2:0]      s1_d, s1_q;
  logic [2:0]      s2_d, s2_q;
  logic [2:0]      db_d, db_q;
  logic [2:0][7:0] cnt_d, cnt_q;
  logic            db_haz_dly_d, db_haz_dly_q;
  logic            haz_d, haz_q;
  turn_state_e     state_d, state_q;

  assign raw = {sw_hazard, sw_right, sw_left};

  // Two-flop synchroniser chain for every raw input.
  always_comb begin
    s1_d = raw;
    s2_d = s1_q;
  end

  // Per-channel debounce: a change is accepted only after DEBOUNCE_CYCLES
  // consecutive synchronised samples differ from the held level; any sample
  // that agrees with the held level restarts the run.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]  = s2_q[i];
        cnt_d[i] = 8'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // Hazard latch toggles on the rising edge of the debounced button only,
  // so a press held indefinitely toggles once and a release does nothing.
  always_comb begin
    db_haz_dly_d = db_q[CH_H];
    haz_d        = haz_q ^ (db_q[CH_H] & ~db_haz_dly_q);
  end

  // Turn arbitration: the first request holds; simultaneous requests from
  // idle are treated as a conflict and ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (db_q[CH_L] && !db_q[CH_R]) begin
          state_d = ST_LEFT;
        end else if (db_q[CH_R] && !db_q[CH_L]) begin
          state_d = ST_RIGHT;
        end
      end
      ST_LEFT: begin
        if (!db_q[CH_L]) begin
          state_d = db_q[CH_R] ? ST_RIGHT : ST_IDLE;
        end
      end
      ST_RIGHT: begin
        if (!db_q[CH_R]) begin
          state_d = db_q[CH_L] ? ST_LEFT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      db_q         <= '0;
      cnt_q        <= '0;
      db_haz_dly_q <= 1'b0;
      haz_q        <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      db_q         <= db_d;
      cnt_q        <= cnt_d;
      db_haz_dly_q <= db_haz_dly_d;
      haz_q        <= haz_d;
      state_q      <= state_d;
    end
  end

  // Outputs decode registers only; hazard masks both turn requests.
  assign Emergency  = haz_q;
  assign Turn_Left  = (state_q == ST_LEFT)  & ~haz_q;
  assign Turn_Right = (state_q == ST_RIGHT) & ~haz_q;

endmodule

// File: doc/vlc_input_conditioner.md
# vlc_input_conditioner

Input conditioning stage placed directly upstream of the vehicle lighting controller. It takes the raw, asynchronous driver controls (left stalk, right stalk, hazard push-button) and synchronises and debounces them. It arbitrates the two turn requests and turns the momentary hazard button into a latched on/off state. Its three outputs drive `Turn_Left`, `Turn_Right` and `Emergency` of the lighting controller as clean, glitch-free, mutually consistent levels.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 4: number of consecutive cycles a synchronised input must differ from its debounced value before the change is accepted. Legal range is 2..255; the counter is 8 bits.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `sw_left`  in  1  raw left-turn stalk level, asynchronous, may bounce.
- `sw_right`  in  1  raw right-turn stalk level, asynchronous, may bounce.
- `sw_hazard`  in  1  raw hazard push-button (momentary, 1 = pressed), asynchronous, may bounce.
- `Turn_Left`  out  1  clean left-turn request.
- `Turn_Right`  out  1  clean right-turn request.
- `Emergency`  out  1  latched hazard state.

## Operation

- **Reset.** While `rst`=1 at a clock edge, all synchroniser flops, debounced levels, counters, the FSM and the hazard latch clear to 0. All outputs read 0 the cycle after reset.
- **Synchroniser.** Each raw input passes through a 2-flop chain (`s1`, `s2`).
- **Debouncer (per channel).** Each channel holds a stable level `db` and an 8-bit counter `cnt`:
  - If `s2 == db`: `cnt` <= 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `db` <= `s2`, `cnt` <= 0.
  - Else: `cnt` <= `cnt`+1.
  - Any bounce back to the old value clears the counter, so the run must restart.
- **Turn FSM.** States are IDLE, LEFT and RIGHT, driven by `db_left`/`db_right`:
  - From IDLE:
    - left only -> LEFT.
    - right only -> RIGHT.
    - both or neither -> stay in IDLE. A conflicting request is ignored.
  - From LEFT:
    - `db_left`=0 and `db_right`=1 -> RIGHT.
    - `db_left`=0 and `db_right`=0 -> IDLE.
    - `db_left`=1 -> stay in LEFT, even if right is also asserted. The first request holds.
  - RIGHT mirrors LEFT.
- **Hazard latch.**
  - `db_haz_d` is a one-cycle delay of `db_haz`.
  - A rising edge (`db_haz`=1, `db_haz_d`=0) toggles `haz`. A release does nothing.
  - A press held indefinitely toggles exactly once.
- **Outputs.**
  - `Emergency` = `haz`.
  - `Turn_Left` = (state==LEFT) & ~`haz`.
  - `Turn_Right` = (state==RIGHT) & ~`haz`.
  - Outputs are decoded only from registers; there is no combinational path from the inputs.
  - While the hazard latch is set, both turn outputs are 0, but the FSM keeps tracking the stalks. When the hazard is cleared, the turn outputs immediately reflect the current state.
- `Turn_Left` and `Turn_Right` are never both 1.

## Timing

- **Turn latency.** Let the raw level first be sampled at edge k (into `s1`):
  - `s2` updates at edge k+1.
  - `db` updates at edge k+1+`DEBOUNCE_CYCLES`.
  - The FSM, and therefore the `Turn_*` outputs, update at edge k+2+`DEBOUNCE_CYCLES`.
  - With the default of 4, the output changes 6 edges after the sampling edge.
- **Hazard latency.** `haz` toggles at edge k+2+`DEBOUNCE_CYCLES`, the same as the turn path.
- **Short pulses.** A raw pulse or glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no output change.
- **Simultaneous changes.** Left and right debouncing to 1 at the same edge from IDLE -> stay in IDLE. Left releasing at the same edge right asserts, while in LEFT -> RIGHT at the next edge.
- **Reset mid-operation.** A reset asserted during a debounce run or while the latch is set clears everything in that cycle. Inputs still held high after reset are re-debounced from scratch with the full latency.
- **Counter range.** The counter never exceeds `DEBOUNCE_CYCLES-1`; there is no wrap.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4.

1. **Reset.** Hold `rst`=1 for 3 cycles with all raw inputs at 1 -> all outputs 0. After release, `Turn_Left` stays 0 because of the both-asserted conflict. `Emergency` rises at the 6th edge after release.
2. **Clean left.** Assert `sw_left` steady -> `Turn_Left`=1 exactly 6 edges after the first sampling edge. Deassert -> `Turn_Left`=0 6 edges later. `Turn_Right` stays 0 throughout.
3. **Bounce rejection.** `sw_right` toggles 1,0,1,0 every 2 cycles, then holds 1 -> no output change during the bounce. `Turn_Right`=1 6 edges after the final stable 1 is sampled.
4. **Turn arbitration.**
   - In LEFT, assert `sw_right` as well -> stays in LEFT.
   - Then release `sw_left` -> `Turn_Left`=0 and `Turn_Right`=1 at the same edge, 6 edges after the release.
   - From IDLE, assert both stalks together -> both outputs stay 0.
5. **Hazard toggle.**
   - Press `sw_hazard` for 20 cycles with `Turn_Left` active -> `Emergency`=1 and `Turn_Left`=0. `Emergency` holds after release.
   - A second press -> `Emergency`=0 and `Turn_Left`=1 restored at the same edge.
   - A 3-cycle press -> no toggle.
6. **Reset mid-debounce.** Assert `rst` after `sw_left` has been sampled high for 3 cycles -> no output change. After reset is released, the full 6-edge latency applies again.
